ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Sits between the core and the single-port zeroDelayRAM (combinational read, write on clock edge when WriteControl=1).
- Shares that one RAM port between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Arbitrates round-robin and converts byte/halfword stores into a two-cycle read-modify-write.
- Flags misaligned LSU accesses instead of performing them.

Parameters:
- dataW, 32, RAM word width in bits; fixed at 32 for byte-lane logic.
- RAMAddrSize, 8, RAM byte-address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- IfReq  in  1  fetch request; held until IfValid.
- IfAddr  in  RAMAddrSize  fetch byte address; bits [1:0] ignored.
- IfData  out  dataW  fetched word; valid while IfValid=1.
- IfValid  out  1  one-cycle fetch completion pulse.
- LsReq  in  1  LSU request; held with stable fields until LsDone.
- LsWrite  in  1  1=store, 0=load.
- LsSize  in  2  store size: 00=byte, 01=half, 10=word, 11=illegal.
- LsAddr  in  RAMAddrSize  LSU byte address.
- LsWData  in  dataW  store data, right-aligned (byte in [7:0], half in [15:0]).
- LsRData  out  dataW  loaded aligned word; valid while LsDone=1.
- LsDone  out  1  one-cycle LSU completion pulse.
- LsErr  out  1  high with LsDone when the access was rejected.
- RAMAddr  out  RAMAddrSize  to RAM; always word-aligned ({addr[RAMAddrSize-1:2],2'b00}).
- DataIn  out  dataW  write data to RAM.
- WriteControl  out  1  RAM write enable.
- DataOut  in  dataW  RAM read data, combinational from RAMAddr.

Behaviour:
Reset
- reset=0 at a rising edge sets state=IDLE, LastGrant=LS (so fetch wins first), and IfValid, LsDone, LsErr, IfData, LsRData all to 0.
- WriteControl is forced to 0 in any cycle where reset=0, including mid-RMW. The aborted store is never written.

States: IDLE, RMW_WR.
- In IDLE with no eligible request: RAMAddr=0, DataIn=0, WriteControl=0.

Eligibility
- A requester is eligible if its Req=1 and its own Done/Valid is not high in this cycle. This gives a one-cycle bubble per requester so a held Req is not re-served.

Arbitration (IDLE only)
- Only one eligible requester: it wins.
- Both eligible: the one that is not LastGrant wins.
- LastGrant is updated on every grant.

Granted fetch
- RAMAddr=aligned IfAddr.
- DataOut is captured into IfData; IfValid=1 on the next cycle.
- Latency: 1 cycle from grant.

Granted LSU load
- DataOut is captured into LsRData; LsDone=1 on the next cycle.

Granted LSU word store
- Aligned only: DataIn=LsWData and WriteControl=1 in the grant cycle; LsDone next cycle.

Granted LSU byte/half store
- Grant cycle: DataOut is captured into a merge register, lane = LsAddr[1:0], then go to RMW_WR.
- RMW_WR: DataIn = merge word with LsWData inserted at the selected lane(s), WriteControl=1, then return to IDLE. LsDone is asserted the following cycle.
- Fetch is stalled during RMW_WR. Total store latency: 2 cycles.

Errors
- Halfword with LsAddr[0]=1, word with LsAddr[1:0]!=0, or LsSize=11 on a store (loads: only the word-alignment rule applies).
- Response: no RAM write, LsRData=0, LsDone=1 and LsErr=1 on the next cycle.

LsRData/IfData hold their value between pulses.

Requesters changing fields while Req is held is a protocol violation; the bench asserts against it.

Decomposition:
- Package ram_arb_pkg: size enum (SZ_BYTE, SZ_HALF, SZ_WORD), state enum (IDLE, RMW_WR), requester id enum (REQ_IF, REQ_LS).
- Sub-module store_merge (combinational): word, data, size, lane -> merged word. Used in RMW_WR.

Test Plan:
1. Reset then LsReq word store addr 64 data 90; next access a load of 64 -> WriteControl high one cycle with RAMAddr=64, DataIn=90; LsDone the next cycle; load returns LsRData=90.
2. IfReq and LsReq (load 68) raised together after reset -> fetch granted first (IfValid cycle 1), LSU granted next eligible cycle. With both held continuously, grants alternate IF,LS,IF,LS.
3. Word at 8 = 0x11223344, byte store 0xAA at addr 9 -> RAM write in RMW_WR of 0x1122AA44, LsDone 2 cycles after grant; concurrent IfReq stalled during RMW_WR.
4. Halfword store 0xBEEF at addr 66 over 0x00000000 at 64 -> write 0xBEEF0000. Halfword at addr 65 -> LsErr=1, LsDone=1, no WriteControl pulse, RAM unchanged.
5. Drop reset to 0 during RMW_WR of a byte store -> WriteControl=0 in that cycle, RAM word unchanged, state IDLE, all outputs 0 after the edge.
6. IfReq held with IfAddr=0x13 -> RAMAddr=0x10, IfValid pulses every other cycle (bubble rule), IfData equals the RAM word at 0x10.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types for the RAM access arbiter: LSU access size, arbiter FSM
// state, requester identity, plus the LSU access legality rule.
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  // Loads must be word aligned; stores must be aligned to their own size.
  function automatic logic ls_access_bad(input logic       write,
                                         input size_e      size,
                                         input logic [1:0] lane);
    logic bad;
    if (!write) begin
      bad = (lane != 2'b00);
    end else begin
      case (size)
        SZ_BYTE: bad = 1'b0;
        SZ_HALF: bad = lane[0];
        SZ_WORD: bad = (lane != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// ---------------------------------------------------------------------------
// store_merge
// Combinational byte-lane merge for sub-word stores.
//   i_word   : current RAM word
//   i_data   : right-aligned store data
//   i_size   : access size
//   i_lane   : byte address bits [1:0]
//   o_merged : i_word with the selected lane(s) replaced by i_data
// ---------------------------------------------------------------------------
module store_merge
  import ram_arb_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_data,
  input  size_e             i_size,
  input  logic [1:0]        i_lane,
  output logic [DATA_W-1:0] o_merged
);

  always_comb begin
    // NOTE: a full default before the case keeps every path assigned, so no latch is inferred.
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        case (i_lane)
          2'd0:    o_merged[7:0]   = i_data[7:0];
          2'd1:    o_merged[15:8]  = i_data[7:0];
          2'd2:    o_merged[23:16] = i_data[7:0];
          default: o_merged[31:24] = i_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (i_lane[1]) o_merged[31:16] = i_data[15:0];
        else           o_merged[15:0]  = i_data[15:0];
      end
      SZ_WORD: o_merged = i_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter
// Shares one single-port, combinational-read RAM between the instruction
// fetch unit (read only) and the load/store unit (read/write). Round-robin
// arbitration; byte/halfword stores become a two-cycle read-modify-write;
// misaligned LSU accesses are rejected with LsErr.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-low reset
//   IfReq/IfAddr          : fetch request (held until IfValid)
//   IfData/IfValid        : fetched word, one-cycle completion pulse
//   LsReq/LsWrite/LsSize/
//   LsAddr/LsWData        : LSU request (held, stable, until LsDone)
//   LsRData/LsDone/LsErr  : load data, completion pulse, rejection flag
//   RAMAddr/DataIn/
//   WriteControl/DataOut  : RAM port (word-aligned address)
// ---------------------------------------------------------------------------
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int dataW       = DATA_W,
  parameter int RAMAddrSize = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   IfReq,
  input  logic [RAMAddrSize-1:0] IfAddr,
  output logic [dataW-1:0]       IfData,
  output logic                   IfValid,
  input  logic                   LsReq,
  input  logic                   LsWrite,
  input  logic [1:0]             LsSize,
  input  logic [RAMAddrSize-1:0] LsAddr,
  input  logic [dataW-1:0]       LsWData,
  output logic [dataW-1:0]       LsRData,
  output logic                   LsDone,
  output logic                   LsErr,
  output logic [RAMAddrSize-1:0] RAMAddr,
  output logic [dataW-1:0]       DataIn,
  output logic                   WriteControl,
  input  logic [dataW-1:0]       DataOut
);

  state_e           r_state;
  req_id_e          r_last_grant;
  logic             r_if_valid;
  logic             r_ls_done;
  logic             r_ls_err;
  logic [dataW-1:0] r_if_data;
  logic [dataW-1:0] r_ls_rdata;
  logic [dataW-1:0] r_merge;

  logic                   w_if_elig;
  logic                   w_ls_elig;
  logic                   w_ls_bad;
  logic                   w_grant_if;
  logic                   w_grant_ls;
  logic                   w_word_store;
  logic                   w_capture_merge;
  logic                   w_we;
  logic [RAMAddrSize-1:0] w_if_addr;
  logic [RAMAddrSize-1:0] w_ls_addr;
  logic [RAMAddrSize-1:0] w_ram_addr;
  logic [dataW-1:0]       w_data_in;
  logic [dataW-1:0]       w_merged;
  size_e                  w_size;
  logic                   w_unused_if_lane;

  assign w_size           = size_e'(LsSize);
  assign w_if_addr        = {IfAddr[RAMAddrSize-1:2], 2'b00};
  assign w_ls_addr        = {LsAddr[RAMAddrSize-1:2], 2'b00};
  assign w_ls_bad         = ls_access_bad(LsWrite, w_size, LsAddr[1:0]);
  assign w_word_store     = (w_size == SZ_WORD);
  assign w_unused_if_lane = ^IfAddr[1:0];

  // A requester whose completion pulse is high this cycle sits out one cycle,
  // so a request still held during its own completion is not served twice.
  assign w_if_elig = IfReq && !r_if_valid;
  assign w_ls_elig = LsReq && !r_ls_done;

  always_comb begin
    w_grant_if = 1'b0;
    w_grant_ls = 1'b0;
    if (r_state == IDLE) begin
      if (w_if_elig && w_ls_elig) begin
        if (r_last_grant == REQ_LS) w_grant_if = 1'b1;
        else                        w_grant_ls = 1'b1;
      end else begin
        w_grant_if = w_if_elig;
        w_grant_ls = w_ls_elig;
      end
    end
  end

  assign w_capture_merge = w_grant_ls && !w_ls_bad && LsWrite && !w_word_store;

  store_merge u_store_merge (
    .i_word   (r_merge),
    .i_data   (LsWData),
    .i_size   (w_size),
    .i_lane   (LsAddr[1:0]),
    .o_merged (w_merged)
  );

  // RAM port is combinational: the read data of a grant cycle is captured at its end.
  always_comb begin
    w_ram_addr = '0;
    w_data_in  = '0;
    w_we       = 1'b0;
    if (r_state == RMW_WR) begin
      w_ram_addr = w_ls_addr;
      w_data_in  = w_merged;
      w_we       = 1'b1;
    end else if (w_grant_if) begin
      w_ram_addr = w_if_addr;
    end else if (w_grant_ls && !w_ls_bad) begin
      w_ram_addr = w_ls_addr;
      if (LsWrite && w_word_store) begin
        w_data_in = LsWData;
        w_we      = 1'b1;
      end
    end
  end

  assign RAMAddr      = w_ram_addr;
  assign DataIn       = w_data_in;
  // Reset gates the write strobe directly so an in-flight RMW never commits.
  assign WriteControl = w_we && reset;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_LS;
      r_if_valid   <= 1'b0;
      r_ls_done    <= 1'b0;
      r_ls_err     <= 1'b0;
      r_if_data    <= '0;
      r_ls_rdata   <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_ls_done  <= 1'b0;
      r_ls_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_if) begin
            r_last_grant <= REQ_IF;
            r_if_data    <= DataOut;
            r_if_valid   <= 1'b1;
          end else if (w_grant_ls) begin
            r_last_grant <= REQ_LS;
            if (w_ls_bad) begin
              r_ls_rdata <= '0;
              r_ls_done  <= 1'b1;
              r_ls_err   <= 1'b1;
            end else if (!LsWrite) begin
              r_ls_rdata <= DataOut;
              r_ls_done  <= 1'b1;
            end else if (w_word_store) begin
              r_ls_done <= 1'b1;
            end else begin
              r_state <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          r_state   <= IDLE;
          r_ls_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: pure datapath register, always loaded before it is read, so it carries no reset.
  always_ff @(posedge clock) begin
    if (w_capture_merge) r_merge <= DataOut;
  end

  assign IfData  = r_if_data;
  assign IfValid = r_if_valid;
  assign LsRData = r_ls_rdata;
  assign LsDone  = r_ls_done;
  assign LsErr   = r_ls_err;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_access_arbiter
// Directed scenarios plus randomized LSU/fetch traffic against a
// transaction-level memory model. The RAM itself is a behavioural
// zero-delay RAM; expected data comes from ref_mem, updated by store rules.
// ---------------------------------------------------------------------------
module tb_ram_access_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        IfReq;
  logic [7:0]  IfAddr;
  logic [31:0] IfData;
  logic        IfValid;
  logic        LsReq;
  logic        LsWrite;
  logic [1:0]  LsSize;
  logic [7:0]  LsAddr;
  logic [31:0] LsWData;
  logic [31:0] LsRData;
  logic        LsDone;
  logic        LsErr;
  logic [7:0]  RAMAddr;
  logic [31:0] DataIn;
  logic        WriteControl;
  logic [31:0] DataOut;

  always #5 clock = ~clock;

  ram_access_arbiter #(.dataW(32), .RAMAddrSize(8)) dut (
    .clock(clock), .reset(reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfData(IfData), .IfValid(IfValid),
    .LsReq(LsReq), .LsWrite(LsWrite), .LsSize(LsSize), .LsAddr(LsAddr),
    .LsWData(LsWData), .LsRData(LsRData), .LsDone(LsDone), .LsErr(LsErr),
    .RAMAddr(RAMAddr), .DataIn(DataIn), .WriteControl(WriteControl),
    .DataOut(DataOut)
  );

  // Behavioural zero-delay RAM; the bench preloads it through the poke port.
  logic [31:0] ram [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx;
  logic [31:0] poke_data;

  assign DataOut = ram[RAMAddr[7:2]];

  always @(posedge clock) begin
    if (poke_en)           ram[poke_idx]     <= poke_data;
    else if (WriteControl) ram[RAMAddr[7:2]] <= DataIn;
  end

  // Requesters must keep fields stable while a request is held.
  logic        p_ls_req = 1'b0;
  logic        p_if_req = 1'b0;
  logic [42:0] p_ls_fields;
  logic [7:0]  p_if_addr;

  always @(posedge clock) begin
    if (p_ls_req && LsReq)
      assert ({LsWrite, LsSize, LsAddr, LsWData} === p_ls_fields)
        else $error("FAIL protocol_ls: LSU fields changed while LsReq held");
    if (p_if_req && IfReq)
      assert (IfAddr === p_if_addr)
        else $error("FAIL protocol_if: IfAddr changed while IfReq held");
    p_ls_req    <= LsReq;
    p_if_req    <= IfReq;
    p_ls_fields <= {LsWrite, LsSize, LsAddr, LsWData};
    p_if_addr   <= IfAddr;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] ref_mem [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    poke_idx  = 6'(idx);
    poke_data = data;
    poke_en   = 1'b1;
    tick();
    poke_en      = 1'b0;
    ref_mem[idx] = data;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    IfReq = 1'b0;
    LsReq = 1'b0;
    tick();
    check("rst_if_valid", 32'(IfValid), 0);
    check("rst_ls_done", 32'(LsDone), 0);
    check("rst_ls_err", 32'(LsErr), 0);
    check("rst_if_data", IfData, 0);
    check("rst_ls_rdata", LsRData, 0);
    check("rst_we", 32'(WriteControl), 0);
    check("rst_ram_addr", 32'(RAMAddr), 0);
    tick();
    reset = 1'b1;
  endtask

  // One LSU transaction with IF idle; expectations come from size/alignment rules.
  task automatic ls_txn(input logic wr, input logic [1:0] sz, input logic [7:0] addr,
                        input logic [31:0] wd);
    int          a;
    int          s;
    int          w;
    int          lane;
    int          lat;
    int          n_we;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_word;
    logic [7:0]  we_addr;
    logic [31:0] we_data;
    a    = int'(addr);
    s    = int'(sz);
    w    = a / 4;
    lane = a % 4;
    if (wr) exp_err = (s == 3) || ((a % (1 << s)) != 0);
    else    exp_err = (lane != 0);
    exp_word = ref_mem[w];
    if (wr && !exp_err) begin
      case (s)
        0:       exp_word[8*lane +: 8]       = wd[7:0];
        1:       exp_word[16*(lane/2) +: 16] = wd[15:0];
        default: exp_word                    = wd;
      endcase
    end
    exp_lat = (wr && !exp_err && s != 2) ? 2 : 1;

    LsWrite = wr; LsSize = sz; LsAddr = addr; LsWData = wd; LsReq = 1'b1;
    lat = 0; n_we = 0; we_addr = '0; we_data = '0;
    while (1) begin
      @(negedge clock);
      if (LsDone) break;
      if (WriteControl) begin
        n_we++;
        we_addr = RAMAddr;
        we_data = DataIn;
      end
      if (lat >= 6) break;
      @(posedge clock);
      #1;
      lat++;
    end
    LsReq = 1'b0;
    check("ls_latency", lat, exp_lat);
    check("ls_err", 32'(LsErr), 32'(exp_err));
    check("ls_write_count", n_we, (wr && !exp_err) ? 1 : 0);
    if (!wr || exp_err) check("ls_rdata", LsRData, exp_err ? 32'h0 : ref_mem[w]);
    if (n_we == 1) begin
      check("ls_write_addr", 32'(we_addr), 32'(w * 4));
      check("ls_write_data", we_data, exp_word);
    end
    ref_mem[w] = exp_word;
    tick();
    check("ram_word", ram[w], ref_mem[w]);
  endtask

  task automatic if_fetch(input logic [7:0] addr);
    int lat;
    IfAddr = addr;
    IfReq  = 1'b1;
    lat    = 0;
    while (1) begin
      @(negedge clock);
      if (IfValid || lat >= 6) break;
      @(posedge clock);
      #1;
      lat++;
    end
    IfReq = 1'b0;
    check("if_latency", lat, 1);
    check("if_data", IfData, ref_mem[int'(addr) / 4]);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    IfAddr = '0; LsWrite = 1'b0; LsSize = '0; LsAddr = '0; LsWData = '0;
    apply_reset();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    reset = 1'b1;
    tick();

    // 1: word store then load at 64
    ls_txn(1'b1, 2'b10, 8'd64, 32'd90);
    ls_txn(1'b0, 2'b10, 8'd64, 32'd0);
    check("load64_value", LsRData, 32'd90);

    // 2: simultaneous requests after reset, held: IF,LS,IF,LS,...
    apply_reset();
    tick();
    IfAddr = 8'h20; LsWrite = 1'b0; LsSize = 2'b10; LsAddr = 8'd68; LsWData = '0;
    IfReq = 1'b1; LsReq = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check("alt_if_valid", 32'(IfValid), (c >= 1 && (c - 1) % 2 == 0) ? 1 : 0);
      check("alt_ls_done", 32'(LsDone), (c >= 1 && (c - 1) % 2 == 1) ? 1 : 0);
      if (IfValid) check("alt_if_data", IfData, ref_mem[8]);
      if (LsDone)  check("alt_ls_rdata", LsRData, ref_mem[17]);
      @(posedge clock);
      #1;
    end
    IfReq = 1'b0; LsReq = 1'b0;
    tick(); tick();

    // 3: byte store 0xAA at 9 over 0x11223344, fetch stalled during RMW_WR
    poke(2, 32'h11223344);
    LsWrite = 1'b1; LsSize = 2'b00; LsAddr = 8'd9; LsWData = 32'h000000AA; LsReq = 1'b1;
    @(negedge clock);
    check("rmw_grant_we", 32'(WriteControl), 0);
    @(posedge clock); #1;
    IfAddr = 8'h08; IfReq = 1'b1;
    @(negedge clock);
    check("rmw_we", 32'(WriteControl), 1);
    check("rmw_addr", 32'(RAMAddr), 32'h08);
    check("rmw_data", DataIn, 32'h1122AA44);
    check("rmw_if_stall", 32'(IfValid), 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("rmw_done", 32'(LsDone), 1);
    check("rmw_err", 32'(LsErr), 0);
    check("rmw_if_still_stalled", 32'(IfValid), 0);
    LsReq = 1'b0;
    ref_mem[2] = 32'h1122AA44;
    @(posedge clock); #1;
    @(negedge clock);
    check("rmw_if_valid", 32'(IfValid), 1);
    check("rmw_if_data", IfData, 32'h1122AA44);
    IfReq = 1'b0;
    tick();
    check("rmw_ram", ram[2], 32'h1122AA44);

    // 4: halfword stores, aligned and misaligned
    poke(16, 32'h0);
    ls_txn(1'b1, 2'b01, 8'd66, 32'h0000BEEF);
    check("half_ram", ram[16], 32'hBEEF0000);
    ls_txn(1'b1, 2'b01, 8'd65, 32'h00001234);
    check("half_err_ram", ram[16], 32'hBEEF0000);

    // 5: reset in the middle of a read-modify-write
    poke(5, 32'hCAFEF00D);
    LsWrite = 1'b1; LsSize = 2'b00; LsAddr = 8'd22; LsWData = 32'h00000055; LsReq = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_we", 32'(WriteControl), 0);
    @(posedge clock); #1;
    LsReq = 1'b0;
    check("abort_if_valid", 32'(IfValid), 0);
    check("abort_ls_done", 32'(LsDone), 0);
    check("abort_ls_err", 32'(LsErr), 0);
    check("abort_if_data", IfData, 0);
    check("abort_ls_rdata", LsRData, 0);
    reset = 1'b1;
    tick();
    check("abort_ram", ram[5], 32'hCAFEF00D);
    ls_txn(1'b0, 2'b10, 8'd20, 32'd0);

    // 6: fetch held at 0x13 pulses every other cycle from word 0x10
    IfAddr = 8'h13; IfReq = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check("held_if_valid", 32'(IfValid), (c % 2 == 1) ? 1 : 0);
      if (c % 2 == 0) check("held_ram_addr", 32'(RAMAddr), 32'h10);
      else            check("held_if_data", IfData, ref_mem[4]);
      @(posedge clock); #1;
    end
    IfReq = 1'b0;
    tick(); tick();

    // Randomized traffic against the memory model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        if_fetch(8'($urandom_range(0, 255)));
      end else begin
        logic [7:0] ra;
        ra = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
        ls_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
